// File: rtl/reg_alu_pkg.sv
// Shared definitions for the reg_alu instruction sequencer: instruction classes,
// ALU opcodes, FSM states and instruction field positions.
package reg_alu_pkg;

    typedef enum logic [1:0] {
        CLS_ALU = 2'b00,
        CLS_LDI = 2'b01,
        CLS_RD  = 2'b10,
        CLS_RSV = 2'b11
    } instr_class_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEC,
        S_EXEC,
        S_WB,
        S_CAP,
        S_DONE
    } state_e;

    localparam int CLS_MSB = 15;
    localparam int CLS_LSB = 14;
    localparam int OP_MSB  = 13;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RA_MSB  = 8;
    localparam int RA_LSB  = 6;
    localparam int RB_MSB  = 5;
    localparam int RB_LSB  = 3;
    localparam int IMM_W   = 9;

    typedef struct packed {
        instr_class_e cls;
        alu_op_e      op;
        logic [2:0]   rd;
        logic [2:0]   ra;
        logic [2:0]   rb;
        logic [15:0]  imm;
    } dec_t;

endpackage

// File: rtl/reg_alu_seq_if.sv
// Host-side instruction/status bus and reg_alu control/data bus in one bundle.
interface reg_alu_seq_if #(parameter int CNT_W = 8);

    logic             instr_valid;
    logic [15:0]      instr;
    logic             instr_ready;

    logic             sel;
    logic             wr;
    logic [1:0]       op;
    logic [2:0]       rd_addr_a;
    logic [2:0]       rd_addr_b;
    logic [2:0]       wr_addr;
    logic [15:0]      d_in;
    logic [15:0]      d_out_a;
    logic [15:0]      d_out_b;
    logic             cout;

    logic [15:0]      res_a;
    logic [15:0]      res_b;
    logic             res_valid;
    logic             carry_flag;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] retired;

    modport master (
        output instr_valid, instr,
        input  instr_ready, res_a, res_b, res_valid, carry_flag, done, err, retired
    );

    modport slave (
        input  instr_valid, instr, d_out_a, d_out_b, cout,
        output instr_ready, sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
               res_a, res_b, res_valid, carry_flag, done, err, retired
    );

    modport alu (
        input  sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
        output d_out_a, d_out_b, cout
    );

endinterface

// File: rtl/reg_alu.sv
// Datapath controlled by the sequencer: 8x16 register file with registered
// read ports, a 2-bit-opcode ALU and a carry flop loaded on ALU writes.
module reg_alu
    import reg_alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    reg_alu_seq_if.alu  bus
);

    logic [15:0] rf [8];
    logic [16:0] alu_full;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        alu_full = '0;
        case (alu_op_e'(bus.op))
            OP_ADD:  alu_full = {1'b0, bus.d_out_a} + {1'b0, bus.d_out_b};
            OP_SUB:  alu_full = {1'b0, bus.d_out_a} + {1'b0, ~bus.d_out_b} + 17'd1;
            OP_AND:  alu_full = {1'b0, bus.d_out_a & bus.d_out_b};
            default: alu_full = {1'b0, bus.d_out_a ^ bus.d_out_b};
        endcase
    end

    // NOTE: the register file is deliberately not reset, so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (bus.wr) begin
            rf[bus.wr_addr] <= bus.sel ? alu_full[15:0] : bus.d_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so reads see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.d_out_a <= '0;
            bus.d_out_b <= '0;
            bus.cout    <= 1'b0;
        end else begin
            bus.d_out_a <= rf[bus.rd_addr_a];
            bus.d_out_b <= rf[bus.rd_addr_b];
            if (bus.wr && bus.sel) begin
                bus.cout <= alu_full[16];
            end
        end
    end

endmodule

// File: rtl/reg_alu_seq_dec.sv
// Combinational instruction decoder: splits the latched word into class, op,
// register fields and the extended LDI immediate.
module reg_alu_seq_dec
    import reg_alu_pkg::*;
#(
    parameter bit IMM_SEXT = 1'b0
) (
    input  logic [15:0] instr,
    output dec_t        dec
);

    logic unused_bits;
    assign unused_bits = ^instr[RB_LSB-1:0];

    always_comb begin
        dec.cls = instr_class_e'(instr[CLS_MSB:CLS_LSB]);
        dec.op  = alu_op_e'(instr[OP_MSB:OP_LSB]);
        dec.rd  = instr[RD_MSB:RD_LSB];
        dec.ra  = instr[RA_MSB:RA_LSB];
        dec.rb  = instr[RB_MSB:RB_LSB];
        dec.imm = IMM_SEXT ? {{(16-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]}
                           : {{(16-IMM_W){1'b0}}, instr[IMM_W-1:0]};
    end

endmodule

// File: rtl/reg_alu_seq.sv
// Instruction sequencer: accepts one instruction at a time, walks it through
// DEC/EXEC/WB/CAP/DONE and drives reg_alu controls combinationally from state.
module reg_alu_seq
    import reg_alu_pkg::*;
#(
    parameter bit IMM_SEXT = 1'b0,
    parameter int CNT_W    = 8
) (
    input  logic          clk,
    input  logic          reset,
    reg_alu_seq_if.slave  bus
);

    state_e      state_q;
    state_e      state_d;
    logic [15:0] instr_q;
    dec_t        dec;

    reg_alu_seq_dec #(.IMM_SEXT(IMM_SEXT)) u_dec (
        .instr (instr_q),
        .dec   (dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && bus.instr_valid) begin
                instr_q <= bus.instr;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.instr_valid) state_d = S_DEC;
            S_DEC: begin
                case (dec.cls)
                    CLS_ALU, CLS_RD: state_d = S_EXEC;
                    CLS_LDI:         state_d = S_WB;
                    default:         state_d = S_DONE;
                endcase
            end
            S_EXEC:      state_d = (dec.cls == CLS_RD) ? S_CAP : S_WB;
            S_WB, S_CAP: state_d = S_DONE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Controls decode from the state register, so an async reset drops wr at once.
    always_comb begin
        bus.instr_ready = (state_q == S_IDLE);
        bus.done        = (state_q == S_DONE);
        bus.sel         = 1'b0;
        bus.wr          = 1'b0;
        bus.op          = '0;
        bus.rd_addr_a   = '0;
        bus.rd_addr_b   = '0;
        bus.wr_addr     = '0;
        bus.d_in        = '0;
        case (state_q)
            S_EXEC: begin
                bus.rd_addr_a = dec.ra;
                bus.rd_addr_b = dec.rb;
                if (dec.cls == CLS_ALU) begin
                    bus.op  = dec.op;
                    bus.sel = 1'b1;
                end
            end
            S_WB: begin
                bus.wr      = 1'b1;
                bus.wr_addr = dec.rd;
                if (dec.cls == CLS_LDI) begin
                    bus.d_in = dec.imm;
                end else begin
                    bus.rd_addr_a = dec.ra;
                    bus.rd_addr_b = dec.rb;
                    bus.op        = dec.op;
                    bus.sel       = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.res_a      <= '0;
            bus.res_b      <= '0;
            bus.res_valid  <= 1'b0;
            bus.carry_flag <= 1'b0;
            bus.err        <= 1'b0;
            bus.retired    <= '0;
        end else begin
            bus.res_valid <= (state_q == S_CAP);
            if (state_q == S_CAP) begin
                bus.res_a <= bus.d_out_a;
                bus.res_b <= bus.d_out_b;
            end
            if (state_q == S_DEC && dec.cls == CLS_RSV) begin
                bus.err <= 1'b1;
            end
            if (state_q == S_DONE) begin
                bus.retired <= bus.retired + 1'b1;
                if (dec.cls == CLS_ALU) begin
                    bus.carry_flag <= bus.cout;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_alu_seq.sv
// Self-checking bench: sequencer plus reg_alu against an architectural model
// (register array, carry, error and retire counters).
module tb_reg_alu_seq;

    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    reg_alu_seq_if #(.CNT_W(CNT_W)) bus ();

    reg_alu_seq #(.IMM_SEXT(1'b1), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    reg_alu u_alu (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] m_rf [8];
    logic        m_carry;
    logic        m_err;
    int          m_retired;
    logic [15:0] m_res_a;
    logic [15:0] m_res_b;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_carry   = 1'b0;
        m_err     = 1'b0;
        m_retired = 0;
        m_res_a   = '0;
        m_res_b   = '0;
    endtask

    task automatic check_status(input string tag);
        check({tag, ".ready"},   32'(bus.instr_ready), 32'd1);
        check({tag, ".done_lo"}, 32'(bus.done), 32'd0);
        check({tag, ".retired"}, 32'(bus.retired), 32'(m_retired % (1 << CNT_W)));
        check({tag, ".carry"},   32'(bus.carry_flag), 32'(m_carry));
        check({tag, ".err"},     32'(bus.err), 32'(m_err));
        check({tag, ".res_a"},   32'(bus.res_a), 32'(m_res_a));
        check({tag, ".res_b"},   32'(bus.res_b), 32'(m_res_b));
    endtask

    // Issue one instruction from IDLE (called #1 after an edge) and follow it to IDLE.
    task automatic run(input logic [15:0] ins);
        logic [1:0]  cls;
        logic [2:0]  rd, ra, rb;
        int          lat, exp_wr, exp_rv, n, wr_cnt, rv_cnt, imm, sum;
        logic [19:0] wr_info, exp_info;
        logic [15:0] a, b, r;
        bit          seen_done;

        cls = ins[15:14];
        rd  = ins[11:9];
        ra  = ins[8:6];
        rb  = ins[5:3];
        exp_info = '0;
        exp_wr = 0;
        exp_rv = 0;
        case (cls)
            2'd0: begin
                lat = 4; exp_wr = 1;
                a = m_rf[ra];
                b = m_rf[rb];
                case (ins[13:12])
                    2'd0: begin sum = int'(a) + int'(b); r = 16'(sum); m_carry = (sum > 65535); end
                    2'd1: begin r = 16'(int'(a) - int'(b)); m_carry = (a >= b); end
                    2'd2: begin r = a & b; m_carry = 1'b0; end
                    default: begin r = a ^ b; m_carry = 1'b0; end
                endcase
                m_rf[rd] = r;
                exp_info = {1'b1, rd, 16'h0000};
            end
            2'd1: begin
                lat = 3; exp_wr = 1;
                imm = int'(ins[8:0]);
                if (imm >= 256) imm = imm - 512;
                m_rf[rd] = 16'(imm);
                exp_info = {1'b0, rd, 16'(imm)};
            end
            2'd2: begin
                lat = 4; exp_rv = 1;
                m_res_a = m_rf[ra];
                m_res_b = m_rf[rb];
            end
            default: begin
                lat = 2;
                m_err = 1'b1;
            end
        endcase
        m_retired++;

        check("accept_ready", 32'(bus.instr_ready), 32'd1);
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        n = 0; wr_cnt = 0; rv_cnt = 0; seen_done = 0; wr_info = '0;
        while (!seen_done && n < 12) begin
            @(posedge clk); #1;
            n++;
            bus.instr_valid = 1'b0;
            if (bus.wr) begin
                wr_cnt++;
                wr_info = {bus.sel, bus.wr_addr, bus.d_in};
            end
            if (bus.res_valid) rv_cnt++;
            if (bus.done) seen_done = 1;
        end
        check("done_seen", 32'(seen_done), 32'd1);
        check("latency",   32'(n), 32'(lat));
        check("wr_pulses", 32'(wr_cnt), 32'(exp_wr));
        check("rv_pulses", 32'(rv_cnt), 32'(exp_rv));
        if (exp_wr == 1) check("wr_ctrl", 32'(wr_info), 32'(exp_info));
        @(posedge clk); #1;
        check_status("post");
    endtask

    initial begin
        logic [15:0] ins;
        logic [1:0]  cls;
        int          n;
        bit          hit_wb;

        for (int i = 0; i < 8; i++) m_rf[i] = 'x;
        model_reset();
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        reset           = 1'b1;
        #1;
        check("rst.wr", 32'(bus.wr), 32'd0);
        check("rst.res_valid", 32'(bus.res_valid), 32'd0);
        check_status("rst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle with no valid: nothing moves.
        repeat (3) @(posedge clk);
        #1;
        check_status("idle");

        // LDI r1,#5
        run(16'h4205);
        check("ldi_r1_retired", 32'(bus.retired), 32'd1);

        // Preload every register with random immediates.
        for (int r = 0; r < 8; r++) begin
            ins = 16'($urandom);
            run({2'b01, ins[13:12], 3'(r), ins[8:0]});
        end

        // LDI r2,#0x1FF sign-extends; RD ra=2 returns 0xFFFF, carry untouched.
        run(16'h45FF);
        run({2'b10, 2'b00, 3'd0, 3'd2, 3'd4, 3'd0});
        check("rd_ffff", 32'(bus.res_a), 32'h0000FFFF);

        // r1=0xFFFF, r2=1, r3 = r1 + r2 -> 0 with carry.
        run(16'h43FF);
        run(16'h4401);
        run(16'h0650);
        check("add_carry", 32'(bus.carry_flag), 32'd1);
        run({2'b10, 2'b00, 3'd0, 3'd3, 3'd1, 3'd0});
        check("r3_zero", 32'(bus.res_a), 32'd0);

        // r1 = r1 - r2 with rd == ra, then read the new r1.
        run(16'h1250);
        run({2'b10, 2'b00, 3'd0, 3'd1, 3'd1, 3'd0});
        check("r1_new", 32'(bus.res_a), 32'h0000FFFE);

        // Reserved class sets sticky err; later instructions still run.
        run(16'hC000);
        check("err_set", 32'(bus.err), 32'd1);
        run(16'h4A2A);
        run({2'b10, 2'b00, 3'd0, 3'd5, 3'd5, 3'd0});

        // Random mix checked against the model.
        for (int i = 0; i < 60; i++) begin
            cls = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            ins = 16'($urandom);
            run({cls, ins[13:0]});
        end

        // Reset during WB of an ALU write to r5: write abandoned, state cleared.
        bus.instr       = {2'b00, 2'b00, 3'd5, 3'($urandom), 3'($urandom), 3'd0};
        bus.instr_valid = 1'b1;
        n = 0; hit_wb = 0;
        while (!hit_wb && n < 10) begin
            @(posedge clk); #1;
            n++;
            bus.instr_valid = 1'b0;
            if (bus.wr) hit_wb = 1;
        end
        check("wb_reached", 32'(hit_wb), 32'd1);
        reset = 1'b1;
        model_reset();
        #1;
        check("mid_rst.wr", 32'(bus.wr), 32'd0);
        check_status("mid_rst");
        @(posedge clk);
        #1 reset = 1'b0;
        run({2'b10, 2'b00, 3'd0, 3'd5, 3'd0, 3'd0});

        // Retire counter wraps modulo 2**CNT_W.
        model_reset();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            ins = 16'($urandom);
            run({2'b01, ins[13:0]});
        end
        check("wrap_to_1", 32'(bus.retired), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

endmodule
